// File: rtl/gcd_arbiter.sv
// Round-robin arbiter sharing one start/done GCD core among NUM_REQ requesters.
// Define GCD_TIMEOUT_EN to build the WAIT-state watchdog and drive rsp_err.
module gcd_arbiter #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_x,
  input  logic [NUM_REQ*WIDTH-1:0] req_y,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     rsp_err,
  output logic                     busy,
  output logic                     core_start,
  output logic [WIDTH-1:0]         core_x,
  output logic [WIDTH-1:0]         core_y,
  input  logic                     core_done,
  input  logic [WIDTH-1:0]         core_result
);

  localparam int PW = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t         state;
  logic [PW-1:0]  rr_ptr;
  logic [PW-1:0]  grant;

  logic [PW-1:0]  pick;
  logic           pick_hit;
  logic [PW:0]    sum;
  logic [WIDTH-1:0] pick_x, pick_y;
  logic [NUM_REQ-1:0] pick_oh, grant_oh;
  logic [PW-1:0]  rr_next;

  // Scan downward so the lowest offset from rr_ptr is the last (winning) write.
  always_comb begin
    pick     = '0;
    pick_hit = 1'b0;
    sum      = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      sum = {1'b0, rr_ptr} + (PW+1)'(i);
      if (sum >= (PW+1)'(NUM_REQ)) sum = sum - (PW+1)'(NUM_REQ);
      if (req_valid[sum[PW-1:0]]) begin
        pick     = sum[PW-1:0];
        pick_hit = 1'b1;
      end
    end
  end

  assign pick_x   = req_x[pick*WIDTH +: WIDTH];
  assign pick_y   = req_y[pick*WIDTH +: WIDTH];
  assign pick_oh  = ONE << pick;
  assign grant_oh = ONE << grant;
  assign rr_next  = (grant == PW'(NUM_REQ-1)) ? '0 : grant + 1'b1;

`ifdef GCD_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT+1) > 8) ? $clog2(TIMEOUT+1) : 8;
  logic [TW-1:0] wd_cnt;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      grant      <= '0;
      req_ready  <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      busy       <= 1'b0;
      core_start <= 1'b0;
      core_x     <= '0;
      core_y     <= '0;
`ifdef GCD_TIMEOUT_EN
      rsp_err    <= 1'b0;
      wd_cnt     <= '0;
`endif
    end else begin
      req_ready  <= '0;
      rsp_valid  <= '0;
      core_start <= 1'b0;
`ifdef GCD_TIMEOUT_EN
      rsp_err    <= 1'b0;
`endif
      case (state)
        IDLE: if (pick_hit) begin
          grant     <= pick;
          core_x    <= pick_x;
          core_y    <= pick_y;
          req_ready <= pick_oh;
          busy      <= 1'b1;
          // A zero operand would never terminate the subtract loop; answer locally.
          if (pick_x == '0 || pick_y == '0) begin
            rsp_data  <= pick_x | pick_y;
            rsp_valid <= pick_oh;
            state     <= RESP;
          end else begin
            core_start <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT;
`ifdef GCD_TIMEOUT_EN
          wd_cnt <= '0;
`endif
        end
        WAIT: begin
          if (core_done) begin
            rsp_data  <= core_result;
            rsp_valid <= grant_oh;
            state     <= RESP;
          end
`ifdef GCD_TIMEOUT_EN
          else if (wd_cnt == TW'(TIMEOUT-1)) begin
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= grant_oh;
            state     <= RESP;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          rr_ptr <= rr_next;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_arbiter.sv
// Scoreboard bench for gcd_arbiter: directed jobs, queued expectations, negedge monitor.
module tb_gcd_arbiter;

  localparam int WIDTH   = 8;
  localparam int NUM_REQ = 4;
  localparam int TMO     = 16;

  logic                     clock = 1'b0;
  logic                     reset;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_x, req_y;
  logic [NUM_REQ-1:0]       req_ready, rsp_valid;
  logic [WIDTH-1:0]         rsp_data;
  logic                     rsp_err, busy, core_start;
  logic [WIDTH-1:0]         core_x, core_y;
  logic                     core_done;
  logic [WIDTH-1:0]         core_result;

  gcd_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_x(req_x), .req_y(req_y), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
    .core_start(core_start), .core_x(core_x), .core_y(core_y),
    .core_done(core_done), .core_result(core_result)
  );

  always #5 clock = ~clock;

  // kind: 0 core path, 1 zero bypass, 2 watchdog timeout, 3 dropped by reset
  typedef struct { int idx; int data; int err; int kind; } rsp_t;
  typedef struct { int x; int y; } op_t;

  int   grant_q[$];
  op_t  core_q[$];
  rsp_t rsp_q[$];
  op_t  drv_q[NUM_REQ][$];

  int errors = 0, checks = 0;
  int cyc = 0, last_ready_cyc = 0, last_start_cyc = 0, done_cyc = -100, starts = 0;
  int core_lat = 1;
  bit hang_once = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int gcd(input int a, input int b);
    int t;
    while (b != 0) begin t = a % b; a = b; b = t; end
    return a;
  endfunction

  task automatic push_job(input int idx, input int x, input int y, input int res, input int kind);
    op_t o;
    rsp_t r;
    o.x = x; o.y = y;
    drv_q[idx].push_back(o);
    grant_q.push_back(idx);
    if (kind != 1) core_q.push_back(o);
    if (kind != 3) begin
      r.idx = idx; r.data = res; r.err = (kind == 2) ? 1 : 0; r.kind = kind;
      rsp_q.push_back(r);
    end
  endtask

  // Requester driver: present queue head, retire it on the matching req_ready.
  initial begin
    req_valid = '0; req_x = '0; req_y = '0;
    forever begin
      @(negedge clock);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i] && drv_q[i].size() > 0) void'(drv_q[i].pop_front());
        if (drv_q[i].size() > 0) begin
          req_valid[i] = 1'b1;
          req_x[i*WIDTH +: WIDTH] = WIDTH'(drv_q[i][0].x);
          req_y[i*WIDTH +: WIDTH] = WIDTH'(drv_q[i][0].y);
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  end

  // Core model: Euclid result after core_lat cycles; hang_once swallows one start.
  initial begin
    int a, b;
    core_done = 1'b0; core_result = '0;
    forever begin
      @(negedge clock);
      if (reset && core_start) begin
        a = int'(core_x); b = int'(core_y);
        if (hang_once) hang_once = 1'b0;
        else begin
          repeat (core_lat) @(negedge clock);
          core_result = WIDTH'(gcd(a, b));
          core_done   = 1'b1;
          done_cyc    = cyc;
          @(negedge clock);
          core_done   = 1'b0;
        end
      end
    end
  end

  // Monitor: compare every DUT event against the head of its queue.
  initial begin
    int g;
    op_t o;
    rsp_t r;
    forever begin
      @(negedge clock);
      if (reset) begin
        if (req_ready != '0) begin
          chk("grant_expected", grant_q.size() != 0, 1);
          if (grant_q.size() != 0) begin
            g = grant_q.pop_front();
            chk("req_ready_onehot", req_ready, 32'(1 << g));
          end
          last_ready_cyc = cyc;
        end
        if (core_start) begin
          starts++;
          last_start_cyc = cyc;
          chk("core_start_expected", core_q.size() != 0, 1);
          chk("core_start_with_ready", cyc, last_ready_cyc);
          if (core_q.size() != 0) begin
            o = core_q.pop_front();
            chk("core_x", core_x, o.x);
            chk("core_y", core_y, o.y);
          end
        end
        if (rsp_valid != '0) begin
          chk("rsp_expected", rsp_q.size() != 0, 1);
          if (rsp_q.size() != 0) begin
            r = rsp_q.pop_front();
            chk("rsp_valid_onehot", rsp_valid, 32'(1 << r.idx));
            chk("rsp_data", rsp_data, r.data);
            chk("rsp_err", rsp_err, r.err);
            case (r.kind)
              0: chk("rsp_after_done", cyc, done_cyc + 1);
              1: chk("bypass_rsp_cycle1", cyc, last_ready_cyc);
              default: chk("timeout_rsp_cycle", cyc, last_start_cyc + TMO + 1);
            endcase
          end
        end
      end
    end
  end

  function automatic bit all_idle();
    bit e = (grant_q.size() == 0) && (core_q.size() == 0) && (rsp_q.size() == 0) && !busy;
    for (int i = 0; i < NUM_REQ; i++) if (drv_q[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic drain(input string name, input int limit);
    int n = 0;
    while (!all_idle() && n < limit) begin @(negedge clock); n++; end
    chk(name, n < limit, 1);
    repeat (2) @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clock);
    chk("reset_ctrl_outs", {req_ready, rsp_valid, rsp_err, busy, core_start}, 0);
    chk("reset_data_outs", {rsp_data, core_x, core_y}, 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    int st0, rel_cyc, n;
    reset = 1'b0;
    do_reset();
    chk("idle_busy_after_reset", busy, 0);

    // Basic core job with slow done
    core_lat = 5;
    push_job(0, 48, 18, 6, 0);
    drain("drain_basic", 200);

    // All four requesters from reset: 0,1,2,3,0 with done in the first WAIT cycle
    do_reset();
    core_lat = 1;
    push_job(0, 12, 8, 4, 0);
    push_job(1, 35, 21, 7, 0);
    push_job(2, 9, 6, 3, 0);
    push_job(3, 100, 75, 25, 0);
    push_job(0, 17, 5, 1, 0);
    drain("drain_all_four", 400);

    // Fairness: only 1 and 3 request, must alternate
    push_job(1, 6, 4, 2, 0);    push_job(3, 27, 18, 9, 0);
    push_job(1, 15, 10, 5, 0);  push_job(3, 64, 48, 16, 0);
    push_job(1, 14, 21, 7, 0);  push_job(3, 50, 30, 10, 0);
    push_job(1, 8, 12, 4, 0);   push_job(3, 81, 54, 27, 0);
    drain("drain_fairness", 600);

    // Zero bypass never touches the core
    st0 = starts;
    push_job(2, 0, 35, 35, 1);
    push_job(2, 0, 0, 0, 1);
    push_job(2, 20, 0, 20, 1);
    drain("drain_bypass", 200);
    chk("bypass_no_core_start", starts, st0);

    // Reset during WAIT: job dropped, late done ignored, rr_ptr back at 0
    push_job(1, 10, 4, 2, 0);
    drain("drain_pre_reset", 200);
    core_lat = 20;
    st0 = starts;
    push_job(2, 30, 12, 6, 3);
    n = 0;
    while (starts == st0 && n < 100) begin @(negedge clock); n++; end
    chk("reset_job_started", starts != st0, 1);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("midrst_ctrl_outs", {req_ready, rsp_valid, rsp_err, busy, core_start}, 0);
    chk("midrst_data_outs", {rsp_data, core_x, core_y}, 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    rel_cyc = cyc;
    repeat (25) @(negedge clock);
    chk("late_done_after_release", done_cyc > rel_cyc, 1);
    chk("busy_after_late_done", busy, 0);
    core_lat = 1;
    push_job(0, 21, 14, 7, 0);
    push_job(3, 9, 3, 3, 0);
    drain("drain_post_reset", 200);

`ifdef GCD_TIMEOUT_EN
    // Watchdog: hung core answered with err, queued request then served
    hang_once = 1'b1;
    push_job(1, 40, 16, 0, 2);
    push_job(2, 9, 12, 3, 0);
    drain("drain_timeout", 300);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
